logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit, the successor to the single-function 32-bit AND-with-enable component in the processor's ALU component library. It adds AND/OR/XOR/NOR operation select, a two-stage registered datapath with valid/ready handshaking on both sides, a zero flag, and a completed-operation counter. It sits between the execute-stage issue logic and the ALU result mux wherever a multi-cycle, back-pressurable logic path is needed.

---
 rtl/logic_unit_pipe.sv | 140 ++++++++++++++
 tb/tb_logic_unit_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : Two-stage pipelined bitwise logic unit (AND/OR/XOR/NOR)
//                with valid/ready handshaking on both sides, a registered
//                zero flag and a wrapping completed-operation counter.
//                Optional macro LOGIC_UNIT_PIPE_PARITY_EN adds a registered
//                'parity' output (XOR-reduction of the result).
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     data_operandA,
   input  logic [WIDTH-1:0]     data_operandB,
   input  logic [1:0]           op,
   input  logic                 logic_enable,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     result,
   output logic                 zero,
   output logic [CNT_WIDTH-1:0] op_count
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   ,
   output logic                 parity
`endif
);

   localparam logic [1:0] c_OP_AND = 2'b00;
   localparam logic [1:0] c_OP_OR  = 2'b01;
   localparam logic [1:0] c_OP_XOR = 2'b10;
   localparam logic [1:0] c_OP_NOR = 2'b11;

   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Stage 1 registers: captured operands and control
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [1:0]       r_s1_op;
   logic             r_s1_en;

   // Stage 2 registers: computed result and flags
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic [CNT_WIDTH-1:0] r_op_count;

   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_consume;
   logic [WIDTH-1:0] w_result;

   // Advance chain: a stage moves when it is empty or the stage after it moves,
   // so bubbles collapse and an empty S2 always pulls from S1.
   assign w_s2_adv  = !r_s2_valid || out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign w_consume = r_s2_valid && out_ready;

   assign in_ready  = w_s1_adv;
   assign out_valid = r_s2_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign op_count  = r_op_count;

   // Bitwise operation on the S1 operands; disabled ops yield all-zero
   always_comb begin
      w_result = '0;
      if (r_s1_en) begin
         case (r_s1_op)
            c_OP_AND: w_result = r_s1_a & r_s1_b;
            c_OP_OR:  w_result = r_s1_a | r_s1_b;
            c_OP_XOR: w_result = r_s1_a ^ r_s1_b;
            c_OP_NOR: w_result = ~(r_s1_a | r_s1_b);
            default:  w_result = '0;
         endcase
      end
   end

   // Stage 1 capture of operands when the stage can advance
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= c_OP_AND;
         r_s1_en    <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         r_s1_a     <= data_operandA;
         r_s1_b     <= data_operandB;
         r_s1_op    <= op;
         r_s1_en    <= logic_enable;
      end
   end

   // Stage 2 capture of result and zero flag; held while stalled
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_zero     <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         r_result   <= w_result;
         r_zero     <= (w_result == '0);
      end
   end

   // Completed-operation counter, wraps naturally at full scale
   always_ff @(posedge clock) begin
      if (reset) begin
         r_op_count <= '0;
      end else if (w_consume) begin
         r_op_count <= r_op_count + c_CNT_ONE;
      end
   end

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic r_parity;

   assign parity = r_parity;

   // Parity of the result, travels with the S2 result
   always_ff @(posedge clock) begin
      if (reset) begin
         r_parity <= 1'b0;
      end else if (w_s2_adv) begin
         r_parity <= ^w_result;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_pipe
//  Description : Self-checking bench for logic_unit_pipe using a queue-based
//                reference model of in-flight operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

   localparam int WIDTH     = 32;
   localparam int CNT_WIDTH = 4;

   logic                 clk;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     data_operandA;
   logic [WIDTH-1:0]     data_operandB;
   logic [1:0]           op;
   logic                 logic_enable;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     result;
   logic                 zero;
   logic [CNT_WIDTH-1:0] op_count;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic                 parity;
`endif

   logic_unit_pipe #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clock         (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .op            (op),
      .logic_enable  (logic_enable),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .zero          (zero),
      .op_count      (op_count)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
      ,
      .parity        (parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             p;
      int               t;
   } exp_t;

   exp_t                 q[$];
   logic [WIDTH-1:0]     consumed[$];
   int                   checks;
   int                   errors;
   int                   ncyc;
   logic [CNT_WIDTH-1:0] cnt_model;
   logic                 prev_hold;
   logic [WIDTH-1:0]     prev_res;
   logic                 last_stall;
   logic                 saw_stall;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: the logical function straight from the operation table
   function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [1:0] o, input logic en);
      if (!en) return '0;
      case (o)
         2'd0: return a & b;
         2'd1: return a | b;
         2'd2: return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // One clock: sample at mid-low phase, check against model, step the edge
   task automatic cycle();
      exp_t e;
      #1;
      chk("op_count", WIDTH'(op_count), WIDTH'(cnt_model));
      chk("in_ready", WIDTH'(in_ready), WIDTH'(!(q.size() == 2 && !out_ready)));
      chk("out_valid", WIDTH'(out_valid),
          WIDTH'(q.size() > 0 && (ncyc - q[0].t) >= 2));
      if (prev_hold) begin
         chk("hold_result", result, prev_res);
      end
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready && q.size() > 0) begin
         e = q.pop_front();
         chk("result", result, e.res);
         chk("zero", WIDTH'(zero), WIDTH'(e.z));
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
         chk("parity", WIDTH'(parity), WIDTH'(e.p));
`endif
         consumed.push_back(result);
         cnt_model = cnt_model + 1'b1;
      end
      if (in_valid && in_ready) begin
         e.res = ref_op(data_operandA, data_operandB, op, logic_enable);
         e.z   = (e.res == '0);
         e.p   = ^e.res;
         e.t   = ncyc;
         q.push_back(e);
      end
      last_stall = in_valid && !in_ready;
      prev_hold  = out_valid && !out_ready;
      prev_res   = result;
      @(posedge clk);
      ncyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset      = 1'b0;
      q.delete();
      consumed.delete();
      cnt_model  = '0;
      prev_hold  = 1'b0;
      last_stall = 1'b0;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] o, input logic en);
      in_valid      = v;
      data_operandA = a;
      data_operandB = b;
      op            = o;
      logic_enable  = en;
   endtask

   logic [WIDTH-1:0] ops_exp [4];

   initial begin
      checks = 0; errors = 0; ncyc = 0; cnt_model = '0;
      prev_hold = 1'b0; prev_res = '0; last_stall = 1'b0; saw_stall = 1'b0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      data_operandA = '0; data_operandB = '0; op = 2'd0; logic_enable = 1'b0;
      @(negedge clk);

      // Reset then idle
      do_reset(2);
      #1;
      chk("rst_in_ready", WIDTH'(in_ready), 1);
      chk("rst_out_valid", WIDTH'(out_valid), 0);
      chk("rst_result", result, 0);
      chk("rst_zero", WIDTH'(zero), 0);
      chk("rst_op_count", WIDTH'(op_count), 0);
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
      chk("rst_parity", WIDTH'(parity), 0);
`endif
      @(negedge clk);

      // Sweep with enable off then on, streaming at full rate
      out_ready = 1'b1;
      for (int en = 0; en < 2; en++) begin
         for (int k = 0; k < 10; k++) begin
            drive(1'b1, WIDTH'(k * 1000), WIDTH'(1000), 2'd0, en[0]);
            cycle();
         end
      end
      drive(1'b0, '0, '0, 2'd0, 1'b0);
      repeat (3) cycle();

      // All four operations on fixed patterns
      do_reset(1);
      out_ready = 1'b1;
      for (int o = 0; o < 4; o++) begin
         drive(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, o[1:0], 1'b1);
         cycle();
      end
      drive(1'b0, '0, '0, 2'd0, 1'b0);
      repeat (3) cycle();
      ops_exp[0] = 32'hF000F000;
      ops_exp[1] = 32'hFFF0FFF0;
      ops_exp[2] = 32'h0FF00FF0;
      ops_exp[3] = 32'h000F000F;
      chk("allops_count", WIDTH'(consumed.size()), 4);
      for (int i = 0; i < 4 && i < consumed.size(); i++) begin
         chk($sformatf("allops_%0d", i), consumed[i], ops_exp[i]);
      end

      // Backpressure: 4 back-to-back ops, 3 stalled cycles after first output
      do_reset(1);
      saw_stall = 1'b0;
      out_ready = 1'b1;
      begin
         int sent = 0;
         int stall_left = 3;
         bit started = 0;
         for (int c = 0; c < 20; c++) begin
            if (!last_stall) begin
               if (sent < 4) begin
                  drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
               end else begin
                  drive(1'b0, '0, '0, 2'd0, 1'b0);
               end
            end
            #1;
            if (out_valid && !started) started = 1;
            if (started && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
            end
            #1;
            if (in_valid && in_ready) sent++;
            #1;
            // rewind sampling point is irrelevant: cycle() samples after its own #1
            cycle();
         end
      end
      chk("bp_saw_stall", WIDTH'(saw_stall), 1);
      chk("bp_queue_empty", WIDTH'(q.size()), 0);
      chk("bp_op_count", WIDTH'(op_count), 4);

      // Counter wrap: 17 consumed ops on a 4-bit counter
      do_reset(1);
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
         cycle();
      end
      drive(1'b0, '0, '0, 2'd0, 1'b0);
      repeat (3) cycle();
      chk("wrap_op_count", WIDTH'(op_count), 1);

      // Reset mid-flight drops the op without counting it
      do_reset(1);
      out_ready = 1'b1;
      drive(1'b1, 32'h12345678, 32'h0F0F0F0F, 2'd2, 1'b1);
      cycle();
      drive(1'b0, '0, '0, 2'd0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      cnt_model = '0;
      prev_hold = 1'b0;
      repeat (4) cycle();
      chk("midrst_op_count", WIDTH'(op_count), 0);

      // Randomized traffic with random backpressure
      do_reset(1);
      for (int c = 0; c < 300; c++) begin
         if (!last_stall) begin
            drive(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 9) == 0) data_operandB = ~data_operandA;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drive(1'b0, '0, '0, 2'd0, 1'b0);
      out_ready = 1'b1;
      repeat (4) cycle();
      chk("rand_drained", WIDTH'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
